control_detector: RTL and testbench

//  Sequencer/feeder for the serial sequence detector. Accepts parallel words over a

---
 rtl/control_detector.sv | 190 +++++++++++++++++++
 tb/tb_control_detector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_detector.sv
// -----------------------------------------------------------------------------
// control_detector
//   Sequencer/feeder for a serial sequence detector. Accepts parallel words over
//   a valid/ready handshake and shifts them out MSB-first on dato. Each bit is
//   held for DIV clk cycles (one "bit slot"). bit_strobe marks the last cycle of
//   every slot, and detectada is sampled only on that cycle. Sampled hits are
//   counted in a saturating counter. A sticky alarm is raised when the count
//   reaches umbral.
//
// Parameters
//   W    bits per word (>=2)
//   DIV  clk cycles per serial bit slot (>=1)
//   CW   width of the hit counter and the threshold
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   word_valid  in   requester presents word_data
//   word_data   in   [W]  word to serialise, MSB first
//   word_ready  out  word accepted this cycle when word_valid is also high
//   dato        out  serial bit to the detector
//   bit_strobe  out  one-cycle pulse on the last cycle of each bit slot
//   detectada   in   detector match flag, meaningful while bit_strobe is high
//   umbral      in   [CW] alarm threshold; zero disables the alarm
//   alarma_clr  in   clears cuenta and alarma
//   cuenta      out  [CW] saturating hit count
//   alarma      out  sticky flag: cuenta >= umbral with umbral != 0
//   ocupado     out  high while a word is being shifted
// -----------------------------------------------------------------------------
module control_detector #(
  parameter int W   = 8,
  parameter int DIV = 2,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          word_valid,
  input  logic [W-1:0]  word_data,
  output logic          word_ready,
  output logic          dato,
  output logic          bit_strobe,
  input  logic          detectada,
  input  logic [CW-1:0] umbral,
  input  logic          alarma_clr,
  output logic [CW-1:0] cuenta,
  output logic          alarma,
  output logic          ocupado
);

  localparam int BIT_W  = (W > 1) ? $clog2(W) : 1;
  localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT_IDX = BIT_W'(W - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(DIV - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  logic [W-1:0]        r_shreg;
  logic [BIT_W-1:0]    r_bit_idx;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_dato;
  logic                r_strobe;
  logic                r_ocupado;
  logic [CW-1:0]       r_cuenta;
  logic                r_alarma;

  state_t              w_state_nxt;
  logic [W-1:0]        w_shreg_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [SLOT_W-1:0]   w_slot_nxt;
  logic                w_dato_nxt;
  logic                w_strobe_nxt;
  logic                w_ocupado_nxt;
  logic                w_slot_last;
  logic                w_word_end;
  logic                w_load;
  logic                w_hit;
  logic [CW-1:0]       w_cnt_base;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_alarm_hit;
  logic                w_alarm_nxt;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake decode (combinational). The controller is ready while idle, and
  // also during the final slot of a word so that a queued word follows
  // back-to-back with no idle cycle.
  // ---------------------------------------------------------------------------
  assign w_slot_last = (r_state == ST_SHIFT) && (r_slot == LAST_SLOT);
  assign w_word_end  = w_slot_last && (r_bit_idx == '0);
  assign word_ready  = (r_state == ST_IDLE) || w_word_end;
  assign w_load      = word_valid && word_ready;

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit_idx;
    w_slot_nxt  = r_slot;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_SHIFT;
          w_shreg_nxt = word_data;
          w_bit_nxt   = LAST_BIT_IDX;
          w_slot_nxt  = '0;
        end
      end
      ST_SHIFT: begin
        if (w_slot_last) begin
          if (r_bit_idx != '0) begin
            w_bit_nxt  = r_bit_idx - BIT_W'(1);
            w_slot_nxt = '0;
          end else if (w_load) begin
            w_shreg_nxt = word_data;
            w_bit_nxt   = LAST_BIT_IDX;
            w_slot_nxt  = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_slot_nxt  = '0;
          end
        end else begin
          w_slot_nxt = r_slot + SLOT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The serial outputs are registered from the next-state values. This keeps
  // dato, bit_strobe and ocupado aligned with the state the sequencer is in
  // during each cycle.
  assign w_dato_nxt    = (w_state_nxt == ST_SHIFT) ? w_shreg_nxt[w_bit_nxt] : 1'b0;
  assign w_strobe_nxt  = (w_state_nxt == ST_SHIFT) && (w_slot_nxt == LAST_SLOT);
  assign w_ocupado_nxt = (w_state_nxt == ST_SHIFT);

  // ---------------------------------------------------------------------------
  // Hit counter and alarm next state. When a clear coincides with a counted
  // hit, the hit wins: the count restarts at 1 and the alarm is evaluated
  // against that value.
  // ---------------------------------------------------------------------------
  assign w_hit       = r_strobe & detectada;
  assign w_cnt_base  = alarma_clr ? '0 : r_cuenta;
  assign w_cnt_nxt   = w_hit ? sat_inc(w_cnt_base) : w_cnt_base;
  assign w_alarm_hit = (umbral != '0) && (w_cnt_nxt >= umbral);
  assign w_alarm_nxt = (r_alarma & ~alarma_clr) | w_alarm_hit;

  // ---------------------------------------------------------------------------
  // Registers (asynchronous reset drops any partially shifted word)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_slot    <= '0;
      r_dato    <= 1'b0;
      r_strobe  <= 1'b0;
      r_ocupado <= 1'b0;
      r_cuenta  <= '0;
      r_alarma  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_idx <= w_bit_nxt;
      r_slot    <= w_slot_nxt;
      r_dato    <= w_dato_nxt;
      r_strobe  <= w_strobe_nxt;
      r_ocupado <= w_ocupado_nxt;
      r_cuenta  <= w_cnt_nxt;
      r_alarma  <= w_alarm_nxt;
    end
  end

  assign dato       = r_dato;
  assign bit_strobe = r_strobe;
  assign ocupado    = r_ocupado;
  assign cuenta     = r_cuenta;
  assign alarma     = r_alarma;

endmodule

// File: tb/tb_control_detector.sv
module tb_control_detector;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          word_valid;
  logic [W-1:0]  word_data;
  logic          detectada;
  logic [CW-1:0] umbral;
  logic          alarma_clr;

  logic [1:0]    word_ready;
  logic [1:0]    dato;
  logic [1:0]    bit_strobe;
  logic [1:0]    alarma;
  logic [1:0]    ocupado;
  logic [CW-1:0] cuenta [2];

  // Two instances share the stimulus: one with DIV=2 and one with DIV=1.
  control_detector #(.W(W), .DIV(2), .CW(CW)) u_div2 (
    .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready[0]), .dato(dato[0]), .bit_strobe(bit_strobe[0]),
    .detectada(detectada), .umbral(umbral), .alarma_clr(alarma_clr),
    .cuenta(cuenta[0]), .alarma(alarma[0]), .ocupado(ocupado[0])
  );

  control_detector #(.W(W), .DIV(1), .CW(CW)) u_div1 (
    .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready[1]), .dato(dato[1]), .bit_strobe(bit_strobe[1]),
    .detectada(detectada), .umbral(umbral), .alarma_clr(alarma_clr),
    .cuenta(cuenta[1]), .alarma(alarma[1]), .ocupado(ocupado[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model. A word occupies W*DIV consecutive cycles. Within a word,
  // the cycle offset e selects bit W-1-e/DIV, and the strobe fires when
  // e%DIV == DIV-1.
  bit            m_busy  [2];
  int            m_e     [2];
  logic [W-1:0]  m_word  [2];
  int            m_cnt   [2];
  bit            m_alarm [2];
  int            m_acc   [2];

  logic [15:0]   col_bits [2];
  int            n_str    [2];
  int            n_ocu    [2];

  function automatic int f_div(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic bit f_dato(int k);
    if (!m_busy[k]) return 1'b0;
    return m_word[k][W - 1 - m_e[k] / f_div(k)];
  endfunction

  function automatic bit f_strobe(int k);
    return m_busy[k] && ((m_e[k] % f_div(k)) == f_div(k) - 1);
  endfunction

  function automatic bit f_ready(int k);
    return !m_busy[k] || (m_e[k] == W * f_div(k) - 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_e[k] = 0; m_word[k] = '0;
      m_cnt[k] = 0; m_alarm[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit rdy, str;
      int base;
      rdy = f_ready(k);
      str = f_strobe(k);
      if (word_valid && rdy) begin
        m_busy[k] = 1'b1; m_word[k] = word_data; m_e[k] = 0; m_acc[k]++;
      end else if (m_busy[k]) begin
        if (m_e[k] == W * f_div(k) - 1) m_busy[k] = 1'b0;
        else m_e[k]++;
      end
      base = alarma_clr ? 0 : m_cnt[k];
      if (str && detectada) base = (base >= 255) ? 255 : base + 1;
      m_alarm[k] = (alarma_clr ? 1'b0 : m_alarm[k]) | ((umbral != 0) && (base >= int'(umbral)));
      m_cnt[k] = base;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dato[%0d]", k),       32'(dato[k]),       32'(f_dato(k)));
      chk($sformatf("bit_strobe[%0d]", k), 32'(bit_strobe[k]), 32'(f_strobe(k)));
      chk($sformatf("word_ready[%0d]", k), 32'(word_ready[k]), 32'(f_ready(k)));
      chk($sformatf("ocupado[%0d]", k),    32'(ocupado[k]),    32'(m_busy[k]));
      chk($sformatf("cuenta[%0d]", k),     32'(cuenta[k]),     32'(m_cnt[k]));
      chk($sformatf("alarma[%0d]", k),     32'(alarma[k]),     32'(m_alarm[k]));
    end
  endtask

  task automatic clear_collect();
    for (int k = 0; k < 2; k++) begin
      col_bits[k] = '0; n_str[k] = 0; n_ocu[k] = 0;
    end
  endtask

  // One clock cycle: compare on the falling edge, then advance the model on
  // the rising edge. Inputs change 1 time unit after the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    for (int k = 0; k < 2; k++) begin
      if (bit_strobe[k]) begin
        col_bits[k] = {col_bits[k][14:0], dato[k]};
        n_str[k]++;
      end
      if (ocupado[k]) n_ocu[k]++;
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int guard;
    int hits;
    int nonstr;

    reset = 1'b1; word_valid = 1'b0; word_data = '0; detectada = 1'b0;
    umbral = '0; alarma_clr = 1'b0;
    m_acc[0] = 0; m_acc[1] = 0;
    model_reset();
    clear_collect();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_dato",    32'(dato[k]),       32'd0);
      chk("rst_strobe",  32'(bit_strobe[k]), 32'd0);
      chk("rst_ocupado", 32'(ocupado[k]),    32'd0);
      chk("rst_cuenta",  32'(cuenta[k]),     32'd0);
      chk("rst_alarma",  32'(alarma[k]),     32'd0);
      chk("rst_ready",   32'(word_ready[k]), 32'd1);
    end
    reset = 1'b0;

    // Serialise 8'hA5 on both instances
    cycle();
    clear_collect();
    word_valid = 1'b1; word_data = 8'hA5;
    cycle();
    word_valid = 1'b0;
    repeat (20) cycle();
    chk("a5_bits_div2",  32'(col_bits[0][7:0]), 32'h0A5);
    chk("a5_strobe_div2", 32'(n_str[0]), 32'd8);
    chk("a5_ocup_div2",   32'(n_ocu[0]), 32'd16);
    chk("a5_bits_div1",  32'(col_bits[1][7:0]), 32'h0A5);
    chk("a5_strobe_div1", 32'(n_str[1]), 32'd8);
    chk("a5_ocup_div1",   32'(n_ocu[1]), 32'd8);

    // Back-to-back: FF then 00 with word_valid held
    clear_collect();
    m_acc[0] = 0;
    word_valid = 1'b1; word_data = 8'hFF;
    cycle();
    word_data = 8'h00;
    guard = 0;
    while (m_acc[0] < 2 && guard < 40) begin
      cycle();
      guard++;
    end
    chk("b2b_second_accept_cycle", 32'(guard), 32'd16);
    word_valid = 1'b0;
    repeat (24) cycle();
    chk("b2b_bits",   32'(col_bits[0]), 32'h0000FF00);
    chk("b2b_strobe", 32'(n_str[0]),    32'd16);
    chk("b2b_ocup",   32'(n_ocu[0]),    32'd32);

    // Counting and alarm, umbral=3
    umbral = 8'd3;
    alarma_clr = 1'b1;
    cycle();
    alarma_clr = 1'b0;
    word_valid = 1'b1; word_data = 8'($urandom);
    cycle();
    word_valid = 1'b0;
    hits = 0; nonstr = 0;
    repeat (16) begin
      if (f_strobe(0)) begin
        detectada = (hits < 3);
        if (hits < 3) hits++;
      end else begin
        detectada = (nonstr < 4);
        nonstr++;
      end
      cycle();
    end
    detectada = 1'b0;
    repeat (4) cycle();
    chk("count3_cuenta", 32'(cuenta[0]), 32'd3);
    chk("count3_alarma", 32'(alarma[0]), 32'd1);

    // Saturation, then clear with a simultaneous hit
    alarma_clr = 1'b1;
    cycle();
    alarma_clr = 1'b0;
    word_valid = 1'b1; detectada = 1'b1;
    repeat (540) begin
      word_data = 8'($urandom);
      cycle();
    end
    chk("sat_cuenta", 32'(cuenta[0]), 32'd255);
    chk("sat_alarma", 32'(alarma[0]), 32'd1);
    guard = 0;
    while (!f_strobe(0) && guard < 4) begin cycle(); guard++; end
    alarma_clr = 1'b1;
    cycle();
    alarma_clr = 1'b0; detectada = 1'b0;
    chk("clrhit_cuenta_u3", 32'(cuenta[0]), 32'd1);
    chk("clrhit_alarma_u3", 32'(alarma[0]), 32'd0);
    umbral = 8'd1;
    guard = 0;
    while (!f_strobe(0) && guard < 4) begin cycle(); guard++; end
    alarma_clr = 1'b1; detectada = 1'b1;
    cycle();
    alarma_clr = 1'b0; detectada = 1'b0;
    chk("clrhit_cuenta_u1", 32'(cuenta[0]), 32'd1);
    chk("clrhit_alarma_u1", 32'(alarma[0]), 32'd1);
    word_valid = 1'b0;
    repeat (20) cycle();

    // umbral=0 disables the alarm; raising umbral under cuenta then sets it
    umbral = 8'd0;
    alarma_clr = 1'b1;
    cycle();
    alarma_clr = 1'b0;
    word_valid = 1'b1;
    hits = 0; guard = 0;
    while (hits < 10 && guard < 200) begin
      word_data = 8'($urandom);
      detectada = f_strobe(0);
      if (f_strobe(0)) hits++;
      cycle();
      guard++;
    end
    detectada = 1'b0; word_valid = 1'b0;
    cycle();
    chk("u0_cuenta", 32'(cuenta[0]), 32'd10);
    chk("u0_alarma", 32'(alarma[0]), 32'd0);
    umbral = 8'd5;
    cycle();
    chk("u5_alarma_next", 32'(alarma[0]), 32'd1);
    repeat (20) cycle();

    // Asynchronous reset in the middle of a word
    word_valid = 1'b1; word_data = 8'hFF;
    cycle();
    word_valid = 1'b0;
    repeat (8) cycle();
    chk("pre_rst_ocup", 32'(ocupado[0]), 32'd1);
    chk("pre_rst_dato", 32'(dato[0]),    32'd1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_dato",   32'(dato[0]),    32'd0);
    chk("mid_rst_ocup",   32'(ocupado[0]), 32'd0);
    chk("mid_rst_cuenta", 32'(cuenta[0]),  32'd0);
    chk("mid_rst_alarma", 32'(alarma[0]),  32'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(word_ready[0]), 32'd1);
    chk("post_rst_ready1", 32'(word_ready[1]), 32'd1);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      word_valid = ($urandom_range(3) != 0);
      word_data  = 8'($urandom);
      detectada  = 1'($urandom_range(1));
      alarma_clr = ($urandom_range(31) == 0);
      if ($urandom_range(63) == 0) umbral = 8'($urandom_range(12));
      cycle();
    end
    word_valid = 1'b0; detectada = 1'b0; alarma_clr = 1'b0;
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
